// File: rtl/hilo_muldiv_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// hilo_muldiv_unit
//
// Multicycle multiply/divide unit with the architectural HI/LO registers.
// It sits in the EX stage beside the ALU and owns the mult/multu/div/divu/
// mfhi/mflo/mthi/mtlo operation codes. Multiply and divide are radix-2
// iterative: one step per clock for WIDTH clocks, then one sign-fix clock.
// The result is written to HI/LO in a single update at the end.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous, active-high reset
//   valid    EX-stage instruction is valid and targets this unit
//   op       5-bit ALU operation code
//   a        rs operand (multiplicand / dividend / mthi-mtlo source)
//   b        rt operand (multiplier / divisor)
//   stall    hold the front of the pipeline this cycle
//   busy     iterative operation in flight
//   done     one-cycle pulse: HI/LO were just updated by mult/div
//   hi, lo   architectural HI/LO registers
//   rd_data  combinational mfhi/mflo read data, 0 otherwise
// -----------------------------------------------------------------------------
module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rd_data
);

    localparam logic [4:0] OP_DIV   = 5'b01111;
    localparam logic [4:0] OP_DIVU  = 5'b10000;
    localparam logic [4:0] OP_MULT  = 5'b10001;
    localparam logic [4:0] OP_MULTU = 5'b10010;
    localparam logic [4:0] OP_MFHI  = 5'b10011;
    localparam logic [4:0] OP_MFLO  = 5'b10100;
    localparam logic [4:0] OP_MTHI  = 5'b10101;
    localparam logic [4:0] OP_MTLO  = 5'b10111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    // acc: multiply -> {partial product, multiplier}; divide -> low half is
    // the dividend shifting out on the left while quotient bits enter right.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]     rem_q, rem_d;     // restoring-divide partial remainder
    logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;  // product / quotient negative
    logic               neg_rem_q, neg_rem_d;  // remainder follows dividend sign

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic is_mul_op, is_div_op, is_signed_op, is_known_op, start;

    assign is_mul_op    = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div_op    = (op == OP_DIV)  || (op == OP_DIVU);
    assign is_signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign is_known_op  = is_mul_op || is_div_op ||
                          (op == OP_MFHI) || (op == OP_MFLO) ||
                          (op == OP_MTHI) || (op == OP_MTLO);
    assign start        = valid && (state_q == S_IDLE) && (is_mul_op || is_div_op);

    // ------------------------------------------------------------------
    // Datapath arithmetic (all unconditional, selected below)
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_shift, div_trial;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign mag_a = (is_signed_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign mag_b = (is_signed_op && b[WIDTH-1]) ? (~b + 1'b1) : b;

    // Shift-add: add multiplicand into the upper half when the current
    // multiplier LSB is set; carry is kept in the extra sum bit.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                     (acc_q[0] ? {1'b0, opnd_q} : '0);

    // Restoring step: bring in the next dividend bit, trial-subtract the
    // divisor, keep the difference only if it did not go negative.
    assign div_shift = {rem_q, acc_q[WIDTH-1]};
    assign div_trial = div_shift - {2'b00, opnd_q};

    assign prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    assign quo_fix  = neg_res_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_rem_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            acc_q     <= '0;
            rem_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (cnt_q == '0) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath / register next values
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        acc_d     = acc_q;
        rem_d     = rem_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_div_d  = is_div_op;
                    opnd_d    = is_div_op ? mag_b : mag_a;
                    acc_d     = {{WIDTH{1'b0}}, (is_div_op ? mag_a : mag_b)};
                    rem_d     = '0;
                    cnt_d     = CNT_W'(WIDTH - 1);
                    neg_res_d = is_signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_d = is_signed_op && a[WIDTH-1];
                end else if (valid && op == OP_MTHI) begin
                    hi_d = a;
                end else if (valid && op == OP_MTLO) begin
                    lo_d = a;
                end
            end
            S_RUN: begin
                if (is_div_q) begin
                    if (!div_trial[WIDTH+1]) begin
                        rem_d              = div_trial[WIDTH:0];
                        acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d              = div_shift[WIDTH:0];
                        acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - 1'b1;
            end
            S_FIX: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy    = (state_q != S_IDLE);
        stall   = valid && is_known_op && busy;
        rd_data = '0;
        if (valid && op == OP_MFHI) rd_data = hi_q;
        else if (valid && op == OP_MFLO) rd_data = lo_q;
    end

    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_hilo_muldiv_unit
//
// Directed bench for hilo_muldiv_unit. Inputs change 1 ns after a rising
// edge; outputs are sampled at that same point, well away from the edge.
// Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_hilo_muldiv_unit;

    localparam logic [4:0] OP_DIV   = 5'b01111;
    localparam logic [4:0] OP_DIVU  = 5'b10000;
    localparam logic [4:0] OP_MULT  = 5'b10001;
    localparam logic [4:0] OP_MULTU = 5'b10010;
    localparam logic [4:0] OP_MFLO  = 5'b10100;
    localparam logic [4:0] OP_MTHI  = 5'b10101;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [4:0]  op;
    logic [31:0] a, b;
    logic        stall, busy, done;
    logic [31:0] hi, lo, rd_data;

    int total = 0;
    int bad   = 0;

    hilo_muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk     (clk),
        .reset   (reset),
        .valid   (valid),
        .op      (op),
        .a       (a),
        .b       (b),
        .stall   (stall),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo),
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an op for exactly one edge (E0), then drop valid.
    task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        valid = 1'b1; op = o; a = x; b = y;
        step();
        valid = 1'b0; op = 5'b0; a = '0; b = '0;
    endtask

    // From E0+1, step until done (bounded). Returns cycles to done and the
    // number of sampled cycles with busy high.
    task automatic wait_done(output int cycles, output int busy_cnt);
        cycles   = 0;
        busy_cnt = 0;
        while (!done && cycles < 100) begin
            if (busy) busy_cnt++;
            step();
            cycles++;
        end
    endtask

    task automatic run_op(input string tag, input logic [4:0] o,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cyc, bcnt;
        issue(o, x, y);
        wait_done(cyc, bcnt);
        check({tag, " latency"}, 32'(cyc), 32'd33);
        check({tag, " hi"}, hi, exp_hi);
        check({tag, " lo"}, lo, exp_lo);
    endtask

    initial begin
        int cyc, bcnt, st_cnt;
        reset = 1'b1; valid = 1'b0; op = '0; a = '0; b = '0;
        #1;
        check("reset hi",    hi, 32'h0);
        check("reset lo",    lo, 32'h0);
        check("reset busy",  32'(busy), 32'd0);
        check("reset done",  32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Unknown op and valid=0 are ignored.
        valid = 1'b1; op = 5'b10110; a = 32'hDEAD_BEEF; b = 32'h1;
        #1 check("bad op stall", 32'(stall), 32'd0);
        step();
        check("bad op busy", 32'(busy), 32'd0);
        check("bad op hi",   hi, 32'h0);
        valid = 1'b0; op = OP_MULT;
        step();
        check("valid0 busy", 32'(busy), 32'd0);

        // multu FFFFFFFF * FFFFFFFF
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu busy E0", 32'(busy), 32'd1);
        check("multu hi held", hi, 32'h0);
        wait_done(cyc, bcnt);
        check("multu latency", 32'(cyc), 32'd33);
        check("multu busy cycles", 32'(bcnt), 32'd33);
        check("multu done busy", 32'(busy), 32'd0);
        check("multu hi", hi, 32'hFFFF_FFFE);
        check("multu lo", lo, 32'h0000_0001);
        step();
        check("multu done pulse", 32'(done), 32'd0);

        // mult -3 * 7, then a back-to-back mult issued in the done cycle
        run_op("mult neg", OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        check("b2b done", 32'(done), 32'd1);
        valid = 1'b1; op = OP_MULT; a = 32'h0001_0000; b = 32'h0001_0000;
        #1 check("b2b stall", 32'(stall), 32'd0);
        step();
        valid = 1'b0; op = '0; a = '0; b = '0;
        check("b2b accepted", 32'(busy), 32'd1);
        wait_done(cyc, bcnt);
        check("b2b latency", 32'(cyc), 32'd33);
        check("b2b hi", hi, 32'h0000_0001);
        check("b2b lo", lo, 32'h0000_0000);

        // Divides and corner cases
        run_op("div -7/2",   OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu 7/2",   OP_DIVU, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003);
        run_op("div min/-1", OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("divu 5/0",   OP_DIVU, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF);
        run_op("div -10/0",  OP_DIV,  32'hFFFF_FFF6, 32'h0000_0000, 32'hFFFF_FFF6, 32'h0000_0001);

        // divu 100/7 with a re-issued divu and then mflo while busy
        issue(OP_DIVU, 32'd100, 32'd7);
        valid = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd3;
        #1 check("reissue stall", 32'(stall), 32'd1);
        step();
        step();
        check("reissue hi held", hi, 32'hFFFF_FFF6);
        check("reissue lo held", lo, 32'h0000_0001);
        op = OP_MFLO; a = '0; b = '0;
        step();
        step();
        st_cnt = 0;
        cyc    = 0;
        while (!done && cyc < 100) begin
            if (stall) st_cnt++;
            step();
            cyc++;
        end
        check("mflo stall cycles", 32'(st_cnt), 32'd29);
        check("mflo done stall", 32'(stall), 32'd0);
        check("mflo rd_data", rd_data, 32'h0000_000E);
        check("divu 100/7 hi", hi, 32'h0000_0002);
        valid = 1'b0; op = '0;
        step();

        // Asynchronous reset at RUN cycle 10 of a mult
        issue(OP_MULT, 32'h0000_0003, 32'h0000_0005);
        repeat (10) step();
        check("pre-reset busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async rst busy", 32'(busy), 32'd0);
        check("async rst hi", hi, 32'h0);
        check("async rst lo", lo, 32'h0);
        #1 reset = 1'b0;
        valid = 1'b1; op = OP_MTHI; a = 32'h0000_1234; b = '0;
        step();
        valid = 1'b0; op = '0; a = '0;
        check("mthi hi", hi, 32'h0000_1234);
        check("mthi busy", 32'(busy), 32'd0);
        check("mthi done", 32'(done), 32'd0);
        step();
        check("mthi done later", 32'(done), 32'd0);
        check("mthi lo", lo, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
